// File: rtl/alu_arbiter.sv
// Round-robin front end for the shared ALU: latches one request, runs it through
// the ALU from registered operands, and holds the response until it is consumed.
module alu_arbiter #(
  parameter int WIDTH = 19
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_valid_0,
  input  logic             req_valid_1,
  output logic             req_ready_0,
  output logic             req_ready_1,
  input  logic [4:0]       req_opcode_0,
  input  logic [4:0]       req_opcode_1,
  input  logic [WIDTH-1:0] req_a_0,
  input  logic [WIDTH-1:0] req_a_1,
  input  logic [WIDTH-1:0] req_b_0,
  input  logic [WIDTH-1:0] req_b_1,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic             rsp_id,
  output logic [WIDTH-1:0] rsp_result,
  output logic             rsp_zero,
  output logic             rsp_negative,
  output logic             rsp_err,
  output logic             busy
);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  typedef struct packed {
    logic [4:0]       opcode;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
  } req_t;

  localparam logic [4:0] OP_ADD = 5'd1, OP_SUB = 5'd2, OP_MUL = 5'd3, OP_DIV = 5'd4,
                         OP_INC = 5'd5, OP_DEC = 5'd6, OP_AND = 5'd7, OP_OR  = 5'd8,
                         OP_XOR = 5'd9, OP_NOT = 5'd10;

  state_t           state;
  logic             last_grant;
  req_t             op_q;
  logic             op_id;
  req_t [1:0]       req;
  logic [1:0]       vld;
  logic             gnt;
  logic             accept;
  logic [WIDTH-1:0] alu_res;
  logic             alu_err;

  assign req[0] = '{opcode: req_opcode_0, a: req_a_0, b: req_b_0};
  assign req[1] = '{opcode: req_opcode_1, a: req_a_1, b: req_b_1};
  assign vld    = {req_valid_1, req_valid_0};

  // On contention the requester that did not win last time goes first.
  assign gnt    = (vld == 2'b11) ? ~last_grant : vld[1];
  // rst_n gating keeps ready low while reset is held even though state reads IDLE.
  assign accept = rst_n && (state == IDLE) && (|vld);
  assign req_ready_0 = accept && !gnt;
  assign req_ready_1 = accept &&  gnt;
  assign busy        = (state != IDLE);

  // Error cases leave the result at zero, so zero/negative fall out naturally.
  always_comb begin
    alu_res = '0;
    alu_err = 1'b0;
    case (op_q.opcode)
      OP_ADD: alu_res = op_q.a + op_q.b;
      OP_SUB: alu_res = op_q.a - op_q.b;
      OP_MUL: alu_res = op_q.a * op_q.b;
      OP_DIV: begin
        if (op_q.b == '0) alu_err = 1'b1;
        else              alu_res = op_q.a / op_q.b;
      end
      OP_INC: alu_res = op_q.a + 1'b1;
      OP_DEC: alu_res = op_q.a - 1'b1;
      OP_AND: alu_res = op_q.a & op_q.b;
      OP_OR:  alu_res = op_q.a | op_q.b;
      OP_XOR: alu_res = op_q.a ^ op_q.b;
      OP_NOT: alu_res = ~op_q.a;
      default: alu_err = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      last_grant   <= 1'b1;
      op_q         <= '0;
      op_id        <= 1'b0;
      rsp_valid    <= 1'b0;
      rsp_id       <= 1'b0;
      rsp_result   <= '0;
      rsp_zero     <= 1'b0;
      rsp_negative <= 1'b0;
      rsp_err      <= 1'b0;
    end else begin
      case (state)
        IDLE: if (accept) begin
          op_q       <= req[gnt];
          op_id      <= gnt;
          last_grant <= gnt;
          state      <= EXEC;
        end
        EXEC: begin
          rsp_result   <= alu_res;
          rsp_zero     <= (alu_res == '0);
          rsp_negative <= alu_res[WIDTH-1];
          rsp_err      <= alu_err;
          rsp_id       <= op_id;
          rsp_valid    <= 1'b1;
          state        <= RESP;
        end
        RESP: if (rsp_ready) begin
          rsp_valid <= 1'b0;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: directed vector table, multi-cycle corner sequences and
// randomized traffic checked against an arithmetic reference model.
module tb_alu_arbiter;
  localparam int W = 19;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         req_valid_0, req_valid_1, req_ready_0, req_ready_1;
  logic [4:0]   req_opcode_0, req_opcode_1;
  logic [W-1:0] req_a_0, req_a_1, req_b_0, req_b_1;
  logic         rsp_valid, rsp_ready, rsp_id, rsp_zero, rsp_negative, rsp_err, busy;
  logic [W-1:0] rsp_result;

  alu_arbiter #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid_0(req_valid_0), .req_valid_1(req_valid_1),
    .req_ready_0(req_ready_0), .req_ready_1(req_ready_1),
    .req_opcode_0(req_opcode_0), .req_opcode_1(req_opcode_1),
    .req_a_0(req_a_0), .req_a_1(req_a_1), .req_b_0(req_b_0), .req_b_1(req_b_1),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_result(rsp_result), .rsp_zero(rsp_zero), .rsp_negative(rsp_negative),
    .rsp_err(rsp_err), .busy(busy)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Stimulus state per requester and the model's round-robin memory.
  bit           v_q [2];
  logic [4:0]   op_q[2];
  logic [W-1:0] a_q [2];
  logic [W-1:0] b_q [2];
  bit           last_g;

  typedef struct {
    bit           id;
    logic [4:0]   op;
    logic [W-1:0] a, b;
    logic [W-1:0] res;
    bit           z, n, e;
  } vec_t;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    end
  endtask

  task automatic drive();
    req_valid_0 = v_q[0]; req_opcode_0 = op_q[0]; req_a_0 = a_q[0]; req_b_0 = b_q[0];
    req_valid_1 = v_q[1]; req_opcode_1 = op_q[1]; req_a_1 = a_q[1]; req_b_1 = b_q[1];
  endtask

  function automatic void ref_alu(input logic [4:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                                  output logic [W-1:0] r, output bit e);
    longint unsigned x = a, y = b, m = longint'(1) << W;
    e = 0;
    case (op)
      5'd1:  r = W'((x + y) % m);
      5'd2:  r = W'((x + m - y) % m);
      5'd3:  r = W'((x * y) % m);
      5'd4:  if (y == 0) begin r = '0; e = 1; end else r = W'(x / y);
      5'd5:  r = W'((x + 1) % m);
      5'd6:  r = W'((x + m - 1) % m);
      5'd7:  r = W'(x & y);
      5'd8:  r = W'(x | y);
      5'd9:  r = W'(x ^ y);
      5'd10: r = W'((m - 1) - x);
      default: begin r = '0; e = 1; end
    endcase
  endfunction

  function automatic bit pick();
    if (v_q[0] && v_q[1]) return !last_g;
    return v_q[1];
  endfunction

  // Starts at posedge+1; returns at the negedge where a ready was seen (or the bound expired).
  task automatic wait_ready(input bit id, output int n);
    n = 0;
    @(negedge clk);
    while (!(req_ready_0 || req_ready_1) && n < 6) begin
      @(negedge clk);
      n++;
    end
    chk("grant", 32'({req_ready_1, req_ready_0}), id ? 32'd2 : 32'd1);
  endtask

  // One complete transaction from whichever requesters are currently valid.
  task automatic run_op(input int stall, input int want,
                        output logic [W-1:0] g_res, output bit g_z, output bit g_n,
                        output bit g_e, output bit g_id, output int n);
    bit           id, ee;
    logic [W-1:0] er;
    id = pick();
    if (want >= 0) chk("rr_order", 32'(id), 32'(want));
    ref_alu(op_q[id], a_q[id], b_q[id], er, ee);
    wait_ready(id, n);
    last_g = id;
    @(posedge clk); #1;
    v_q[id] = 0; drive();
    rsp_ready = (stall == 0);
    @(negedge clk);
    chk("exec_state", 32'({rsp_valid, req_ready_1, req_ready_0, busy}), 32'b0001);
    @(posedge clk); @(negedge clk);
    chk("rsp_valid", 32'(rsp_valid), 32'd1);
    chk("rsp_id", 32'(rsp_id), 32'(id));
    chk("rsp_result", 32'(rsp_result), 32'(er));
    chk("rsp_flags", 32'({rsp_zero, rsp_negative, rsp_err}), 32'({er == '0, er[W-1], ee}));
    g_res = rsp_result; g_z = rsp_zero; g_n = rsp_negative; g_e = rsp_err; g_id = rsp_id;
    for (int i = 1; i <= stall; i++) begin
      @(posedge clk); #1;
      if (i == stall) rsp_ready = 1;
      @(negedge clk);
      chk("hold", 32'({rsp_valid, rsp_id, rsp_result, rsp_zero, rsp_negative, rsp_err, req_ready_1, req_ready_0}),
                  32'({1'b1, g_id, g_res, g_z, g_n, g_e, 2'b00}));
    end
    @(posedge clk); #1;
  endtask

  vec_t vecs[16];

  initial begin
    logic [W-1:0] g_res;
    bit g_z, g_n, g_e, g_id;
    int n;

    vecs[0]  = '{0, 5'd1,  19'd5,       19'd7,       19'd12,      0, 0, 0};
    vecs[1]  = '{1, 5'd4,  19'd100,     19'd0,       19'd0,       1, 0, 1};
    vecs[2]  = '{1, 5'd4,  19'd100,     19'd7,       19'd14,      0, 0, 0};
    vecs[3]  = '{0, 5'd15, 19'd3,       19'd4,       19'd0,       1, 0, 1};
    vecs[4]  = '{0, 5'd6,  19'd0,       19'd0,       19'h7FFFF,   0, 1, 0};
    vecs[5]  = '{1, 5'd3,  19'h40000,   19'd2,       19'd0,       1, 0, 0};
    vecs[6]  = '{0, 5'd2,  19'd10,      19'd3,       19'd7,       0, 0, 0};
    vecs[7]  = '{1, 5'd5,  19'h7FFFF,   19'd0,       19'd0,       1, 0, 0};
    vecs[8]  = '{0, 5'd7,  19'h5A5A5,   19'h0FF0F,   19'h0A505,   0, 0, 0};
    vecs[9]  = '{1, 5'd8,  19'h40000,   19'd1,       19'h40001,   0, 1, 0};
    vecs[10] = '{0, 5'd9,  19'h12345,   19'h12345,   19'd0,       1, 0, 0};
    vecs[11] = '{1, 5'd10, 19'd0,       19'd9,       19'h7FFFF,   0, 1, 0};
    vecs[12] = '{0, 5'd0,  19'd1,       19'd1,       19'd0,       1, 0, 1};
    vecs[13] = '{0, 5'd31, 19'd1,       19'd1,       19'd0,       1, 0, 1};
    vecs[14] = '{1, 5'd4,  19'h7FFFF,   19'h10,      19'h7FFF,    0, 0, 0};
    vecs[15] = '{1, 5'd2,  19'd0,       19'd1,       19'h7FFFF,   0, 1, 0};

    // Reset state with both requesters asking: nothing may be granted.
    rst_n = 0; rsp_ready = 0; last_g = 1;
    for (int i = 0; i < 2; i++) begin v_q[i] = 1; op_q[i] = 5'd1; a_q[i] = 19'd1; b_q[i] = 19'd2; end
    drive();
    #2;
    chk("reset_outputs", 32'({busy, rsp_valid, rsp_id, rsp_result, rsp_zero, rsp_negative, rsp_err, req_ready_1, req_ready_0}), 32'd0);
    @(posedge clk); @(posedge clk); #1;
    v_q[0] = 0; v_q[1] = 0; drive();
    rst_n = 1;

    foreach (vecs[k]) begin
      v_q[vecs[k].id] = 1; op_q[vecs[k].id] = vecs[k].op;
      a_q[vecs[k].id] = vecs[k].a; b_q[vecs[k].id] = vecs[k].b;
      drive();
      run_op(0, -1, g_res, g_z, g_n, g_e, g_id, n);
      chk($sformatf("vec%0d", k), 32'({g_id, g_res, g_z, g_n, g_e}),
          32'({vecs[k].id, vecs[k].res, vecs[k].z, vecs[k].n, vecs[k].e}));
    end

    // Contention: both held valid, grants must alternate starting with requester 0.
    v_q[0] = 1; op_q[0] = 5'd2; a_q[0] = 19'd10;     b_q[0] = 19'd3;
    v_q[1] = 1; op_q[1] = 5'd3; a_q[1] = 19'h40000;  b_q[1] = 19'd2;
    drive();
    for (int k = 0; k < 4; k++) begin
      run_op(0, k % 2, g_res, g_z, g_n, g_e, g_id, n);
      chk("contend_rsp", 32'({g_res, g_z, g_n}), (k % 2) ? 32'({19'd0, 1'b1, 1'b0}) : 32'({19'd7, 1'b0, 1'b0}));
      v_q[k % 2] = 1; drive();
    end
    v_q[0] = 0; v_q[1] = 0; drive();

    // Backpressure: response held 5 extra cycles, pending requester taken right after.
    v_q[0] = 1; op_q[0] = 5'd1; a_q[0] = 19'd1;  b_q[0] = 19'd2;
    v_q[1] = 1; op_q[1] = 5'd9; a_q[1] = 19'hF0; b_q[1] = 19'h0F;
    drive();
    run_op(5, 0, g_res, g_z, g_n, g_e, g_id, n);
    run_op(0, 1, g_res, g_z, g_n, g_e, g_id, n);
    chk("bp_next_accept_wait", 32'(n), 32'd0);

    // Reset during EXEC discards the operation and restores the round-robin pointer.
    v_q[0] = 1; op_q[0] = 5'd1; a_q[0] = 19'd3; b_q[0] = 19'd4; drive();
    wait_ready(0, n);
    @(posedge clk); #1;
    rst_n = 0;
    v_q[0] = 1; v_q[1] = 1; drive();
    #1;
    chk("reset_mid_exec", 32'({busy, rsp_valid, rsp_id, rsp_result, rsp_zero, rsp_negative, rsp_err, req_ready_1, req_ready_0}), 32'd0);
    last_g = 1;
    @(posedge clk); @(posedge clk); #1;
    v_q[0] = 0; v_q[1] = 0; drive();
    rst_n = 1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("no_rsp_after_reset", 32'({rsp_valid, busy}), 32'd0);
    end
    @(posedge clk); #1;
    v_q[0] = 1; v_q[1] = 1; drive();
    run_op(0, 0, g_res, g_z, g_n, g_e, g_id, n);
    v_q[1] = 0; drive();

    // Randomized traffic against the reference model.
    for (int k = 0; k < 150; k++) begin
      for (int r = 0; r < 2; r++) begin
        if (!v_q[r] && ($urandom_range(0, 2) != 0)) begin
          v_q[r]  = 1;
          op_q[r] = ($urandom_range(0, 9) == 0) ? 5'($urandom_range(11, 31)) :
                    ($urandom_range(0, 19) == 0) ? 5'd0 : 5'($urandom_range(1, 10));
          a_q[r]  = W'($urandom);
          b_q[r]  = ($urandom_range(0, 5) == 0) ? '0 : W'($urandom_range(0, 3) == 0 ? $urandom_range(1, 15) : $urandom);
        end
      end
      if (!v_q[0] && !v_q[1]) begin
        v_q[0] = 1; op_q[0] = 5'd1; a_q[0] = W'($urandom); b_q[0] = W'($urandom);
      end
      drive();
      run_op(int'($urandom_range(0, 2)), -1, g_res, g_z, g_n, g_e, g_id, n);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d of %0d checks", errors, checks);
    $fatal(1);
  end

endmodule
